// File: rtl/cond_pkg.sv
// Shared ARM condition-code constants, NZCV bit indices and the E-stage register layout.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [3:0] COND_BUBBLE = 4'b1110;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       flag_w;
    logic       mem_to_reg;
    logic       alu_src;
    logic       no_write;
    logic [1:0] alu_control;
    logic [3:0] cond;
    logic [3:0] wa3;
    logic       valid;
  } e_reg_t;

  function automatic e_reg_t bubble();
    e_reg_t b;
    b      = '0;
    b.cond = COND_BUBBLE;
    return b;
  endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator: (cond, NZCV) -> pass/fail.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_stage.sv
// Decode->Execute pipeline register with NZCV flags and condition-gated controls.
// Optional performance counters are built when PERF_CNT_EN is defined.
module cond_exec_stage
  import cond_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        StallE,
  input  logic        FlushE,
  input  logic        PCSD,
  input  logic        RegWD,
  input  logic        MemWD,
  input  logic        FlagWD,
  input  logic        MemtoRegD,
  input  logic        ALUSrcD,
  input  logic        NoWriteD,
  input  logic [1:0]  ALUControlD,
  input  logic [3:0]  CondD,
  input  logic [3:0]  WA3D,
  input  logic [3:0]  ALUFlags,
  output logic [1:0]  ALUControlE,
  output logic        ALUSrcE,
  output logic        MemtoRegE,
  output logic [3:0]  WA3E,
  output logic        PCSrcE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        CondExE,
  output logic [3:0]  FlagsE,
  output logic [31:0] ExecCount,
  output logic [31:0] SquashCount
);

  e_reg_t     e_reg;
  logic [3:0] flags;
  logic       cond_ex;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      e_reg <= bubble();
    end else if (FlushE) begin
      e_reg <= bubble();
    end else if (!StallE) begin
      e_reg <= {PCSD, RegWD, MemWD, FlagWD, MemtoRegD, ALUSrcD, NoWriteD,
                ALUControlD, CondD, WA3D, 1'b1};
    end
  end

  cond_check u_cond_check (
    .cond    (e_reg.cond),
    .flags   (flags),
    .cond_ex (cond_ex)
  );

  assign CondExE = e_reg.valid & cond_ex;

  // Stall gate: a held flag setter must update NZCV exactly once, on release.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      flags <= 4'b0000;
    end else if (e_reg.flag_w && CondExE && !StallE) begin
      flags <= ALUFlags;
    end
  end

  assign PCSrcE      = e_reg.pcs & CondExE;
  assign RegWriteE   = e_reg.reg_w & CondExE & ~e_reg.no_write;
  assign MemWriteE   = e_reg.mem_w & CondExE;
  assign FlagsE      = flags;
  assign ALUControlE = e_reg.alu_control;
  assign ALUSrcE     = e_reg.alu_src;
  assign MemtoRegE   = e_reg.mem_to_reg;
  assign WA3E        = e_reg.wa3;

`ifdef PERF_CNT_EN
  logic [31:0] exec_count;
  logic [31:0] squash_count;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      exec_count   <= '0;
      squash_count <= '0;
    end else if (!StallE) begin
      if (CondExE)
        exec_count <= exec_count + 32'd1;
      if (e_reg.valid && !cond_ex)
        squash_count <= squash_count + 32'd1;
    end
  end

  assign ExecCount   = exec_count;
  assign SquashCount = squash_count;
`else
  assign ExecCount   = 32'd0;
  assign SquashCount = 32'd0;
`endif

endmodule

// File: tb/tb_cond_exec_stage.sv
// Directed self-checking bench for cond_exec_stage (define PERF_CNT_EN to exercise the counters).
module tb_cond_exec_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        StallE, FlushE;
  logic        PCSD, RegWD, MemWD, FlagWD, MemtoRegD, ALUSrcD, NoWriteD;
  logic [1:0]  ALUControlD;
  logic [3:0]  CondD, WA3D, ALUFlags;
  logic [1:0]  ALUControlE;
  logic        ALUSrcE, MemtoRegE;
  logic [3:0]  WA3E;
  logic        PCSrcE, RegWriteE, MemWriteE, CondExE;
  logic [3:0]  FlagsE;
  logic [31:0] ExecCount, SquashCount;

  int tests = 0;
  int fails = 0;

  cond_exec_stage dut (
    .CLK(CLK), .RESET(RESET), .StallE(StallE), .FlushE(FlushE),
    .PCSD(PCSD), .RegWD(RegWD), .MemWD(MemWD), .FlagWD(FlagWD),
    .MemtoRegD(MemtoRegD), .ALUSrcD(ALUSrcD), .NoWriteD(NoWriteD),
    .ALUControlD(ALUControlD), .CondD(CondD), .WA3D(WA3D), .ALUFlags(ALUFlags),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .MemtoRegE(MemtoRegE), .WA3E(WA3E),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .CondExE(CondExE),
    .FlagsE(FlagsE), .ExecCount(ExecCount), .SquashCount(SquashCount)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic drive_d(input logic pcs, input logic regw, input logic memw,
                         input logic flagw, input logic nowrite, input logic [3:0] cond);
    PCSD = pcs; RegWD = regw; MemWD = memw; FlagWD = flagw; NoWriteD = nowrite;
    CondD = cond; MemtoRegD = 1'b0; ALUSrcD = 1'b0; ALUControlD = 2'b00; WA3D = 4'h0;
  endtask

  // Loads an AL flag setter into E; the caller's next edge commits val to FlagsE.
  task automatic set_flags(input logic [3:0] val);
    drive_d(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1110);
    ALUFlags = val;
    tick();
  endtask

  task automatic pulse_reset();
    #2 RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if ({CondExE, RegWriteE, PCSrcE, MemWriteE, FlagsE} !== 8'h00) begin
      fails++; $display("FAIL reset_initial: got %b, expected 00000000", {CondExE, RegWriteE, PCSrcE, MemWriteE, FlagsE});
    end
    RESET = 1'b0;
    drive_d(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1110);
    ALUFlags = 4'b1111;
    tick();
    tests++;
    if (RegWriteE !== 1'b1) begin
      fails++; $display("FAIL reset_pre_regwrite: got %b, expected 1", RegWriteE);
    end
    tick();
    tests++;
    if (FlagsE !== 4'b1111) begin
      fails++; $display("FAIL reset_pre_flags: got %b, expected 1111", FlagsE);
    end
    #2 RESET = 1'b1;
    #1;
    tests++;
    if ({CondExE, RegWriteE, FlagsE} !== 6'b000000) begin
      fails++; $display("FAIL reset_async: got %b, expected 000000", {CondExE, RegWriteE, FlagsE});
    end
    @(negedge CLK);
    tests++;
    if ({CondExE, RegWriteE, FlagsE, ExecCount, SquashCount} !== 70'd0) begin
      fails++; $display("FAIL reset_hold: cond=%b regw=%b flags=%b exec=%h squash=%h, expected all 0",
                        CondExE, RegWriteE, FlagsE, ExecCount, SquashCount);
    end
    RESET = 1'b0;
    drive_d(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1110);
    $display("[TB] test_reset done");
  endtask

  task automatic test_flags_branch();
    drive_d(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1110);  // CMP
    ALUFlags = 4'b0100;
    tick();
    tests++;
    if ({RegWriteE, FlagsE} !== 5'b0_0000) begin
      fails++; $display("FAIL cmp_in_e: regw/flags got %b, expected 00000", {RegWriteE, FlagsE});
    end
    drive_d(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);  // BEQ
    tick();
    tests++;
    if ({PCSrcE, FlagsE} !== 5'b1_0100) begin
      fails++; $display("FAIL beq_taken: pcsrc/flags got %b, expected 10100", {PCSrcE, FlagsE});
    end
    drive_d(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);  // BNE
    tick();
    tests++;
    if (PCSrcE !== 1'b0) begin
      fails++; $display("FAIL bne_not_taken: pcsrc got %b, expected 0", PCSrcE);
    end
    $display("[TB] test_flags_branch done");
  endtask

  task automatic test_signed();
    set_flags(4'b1001);
    drive_d(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1010);  // GE store
    tick();
    tests++;
    if ({FlagsE, MemWriteE} !== 5'b1001_1) begin
      fails++; $display("FAIL ge_pass: flags/memw got %b, expected 10011", {FlagsE, MemWriteE});
    end
    drive_d(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1011);  // LT store
    tick();
    tests++;
    if (MemWriteE !== 1'b0) begin
      fails++; $display("FAIL lt_fail: memw got %b, expected 0", MemWriteE);
    end
    set_flags(4'b1000);
    drive_d(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1100);  // GT
    tick();
    tests++;
    if ({FlagsE, CondExE} !== 5'b1000_0) begin
      fails++; $display("FAIL gt_fail: flags/condex got %b, expected 10000", {FlagsE, CondExE});
    end
    drive_d(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1101);  // LE
    tick();
    tests++;
    if (CondExE !== 1'b1) begin
      fails++; $display("FAIL le_pass: condex got %b, expected 1", CondExE);
    end
    $display("[TB] test_signed done");
  endtask

  task automatic test_cond_table();
    logic [3:0]  fv [4] = '{4'b0000, 4'b0110, 4'b1011, 4'b0001};
    logic [15:0] mk [4] = '{16'h56AA, 16'h66A5, 16'h5556, 16'h6A6A};
    logic [15:0] mask;
    for (int f = 0; f < 4; f++) begin
      set_flags(fv[f]);
      mask = mk[f];
      for (int c = 0; c < 16; c++) begin
        drive_d(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'(c));
        tick();
        ALUFlags = ~fv[f];
        tests++;
        if (PCSrcE !== mask[c]) begin
          fails++; $display("FAIL cond_table flags=%b cond=%0d: pcsrc got %b, expected %b", fv[f], c, PCSrcE, mask[c]);
        end
      end
    end
    $display("[TB] test_cond_table done");
  endtask

  task automatic test_stall();
    logic [31:0] exec0;
    pulse_reset();
    drive_d(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001);  // ADDSNE
    ALUFlags = 4'b0100;
    tick();
    tests++;
    if ({CondExE, RegWriteE} !== 2'b11) begin
      fails++; $display("FAIL stall_load: condex/regw got %b, expected 11", {CondExE, RegWriteE});
    end
    exec0  = ExecCount;
    StallE = 1'b1;
    drive_d(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1110);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({FlagsE, CondExE} !== 5'b0000_1) begin
        fails++; $display("FAIL stall_hold cycle %0d: flags/condex got %b, expected 00001", i, {FlagsE, CondExE});
      end
    end
    StallE = 1'b0;
    tick();
    tests++;
    if (FlagsE !== 4'b0100) begin
      fails++; $display("FAIL stall_release: flags got %b, expected 0100", FlagsE);
    end
`ifdef PERF_CNT_EN
    tests++;
    if (ExecCount !== exec0 + 32'd1) begin
      fails++; $display("FAIL stall_exec_count: got %h, expected %h", ExecCount, exec0 + 32'd1);
    end
`endif
    $display("[TB] test_stall done");
  endtask

  task automatic test_flush();
    logic [31:0] exec0, squash0;
    drive_d(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1110);
    StallE = 1'b1; FlushE = 1'b1;
    exec0 = ExecCount; squash0 = SquashCount;
    tick();
    tests++;
    if ({PCSrcE, RegWriteE, MemWriteE, CondExE} !== 4'b0000) begin
      fails++; $display("FAIL flush_priority: gated got %b, expected 0000", {PCSrcE, RegWriteE, MemWriteE, CondExE});
    end
    tests++;
    if ({ExecCount, SquashCount} !== {exec0, squash0}) begin
      fails++; $display("FAIL flush_counters: got %h/%h, expected %h/%h", ExecCount, SquashCount, exec0, squash0);
    end
    StallE = 1'b0; FlushE = 1'b0;
    tick();
    tests++;
    if ({PCSrcE, RegWriteE, MemWriteE} !== 3'b111) begin
      fails++; $display("FAIL post_flush: gated got %b, expected 111", {PCSrcE, RegWriteE, MemWriteE});
    end
    $display("[TB] test_flush done");
  endtask

  task automatic test_passthrough();
    drive_d(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1110);
    MemtoRegD = 1'b1; ALUSrcD = 1'b1; ALUControlD = 2'b10; WA3D = 4'hA;
    tick();
    tests++;
    if ({MemtoRegE, ALUSrcE, ALUControlE, WA3E} !== 8'b1_1_10_1010) begin
      fails++; $display("FAIL passthrough: got %b, expected 11101010", {MemtoRegE, ALUSrcE, ALUControlE, WA3E});
    end
    $display("[TB] test_passthrough done");
  endtask

  task automatic test_counters();
`ifdef PERF_CNT_EN
    logic [31:0] squash0;
    drive_d(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1110);
    tick();
    force dut.exec_count = 32'hFFFF_FFFF;
    #1 release dut.exec_count;
    @(negedge CLK);
    tests++;
    if (ExecCount !== 32'd0) begin
      fails++; $display("FAIL exec_wrap: got %h, expected 00000000", ExecCount);
    end
    drive_d(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111);
    tick();
    squash0 = SquashCount;
    drive_d(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1110);
    tick();
    tests++;
    if (SquashCount !== squash0 + 32'd1) begin
      fails++; $display("FAIL squash_count: got %h, expected %h", SquashCount, squash0 + 32'd1);
    end
`else
    tests++;
    if ({ExecCount, SquashCount} !== 64'd0) begin
      fails++; $display("FAIL counters_disabled: got %h/%h, expected 0/0", ExecCount, SquashCount);
    end
`endif
    $display("[TB] test_counters done");
  endtask

  initial begin
    RESET = 1'b1; StallE = 1'b0; FlushE = 1'b0; ALUFlags = 4'b0000;
    drive_d(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1110);
    @(negedge CLK);
    test_reset();
    test_flags_branch();
    test_signed();
    test_cond_table();
    test_stall();
    test_flush();
    test_passthrough();
    test_counters();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
